sync_debounce: RTL and testbench



---
 rtl/sync_debounce_pkg.sv | 22 ++
 rtl/sync2ff.sv | 35 +++
 rtl/sync_debounce.sv | 157 +++++++++++++++
 tb/tb_sync_debounce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce_pkg
// Purpose  : Shared state encodings and constants for the sync_debounce
//            conditioning stage (top and bench import this package).
// Contents : state_e      - 2-bit debounce FSM state encoding
//            GLITCH_W     - width of the optional glitch counter
// Revision : 1.0 - initial release
// ============================================================================
package sync_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_CHK_HI  = 2'd1,
        ST_IDLE_HI = 2'd2,
        ST_CHK_LO  = 2'd3
    } state_e;

    localparam int GLITCH_W = 8;

endpackage : sync_debounce_pkg
`default_nettype wire

// File: rtl/sync2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync2ff
// Purpose  : Two-flop synchroniser bringing an asynchronous bit into the clk
//            domain. Plain registers only so the stage can be triplicated.
// Ports    : clk - system clock, rising edge
//            rst - asynchronous active-high reset (both flops to 0)
//            d   - asynchronous input
//            q   - synchronised output (two clk edges of latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule : sync2ff
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Purpose  : Synchronises an asynchronous bit and debounces it with a
//            counter-based FSM. A new level is accepted only after
//            DEBOUNCE_CYCLES consecutive stable synchronised samples.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            in_async   - raw asynchronous input
//            en         - evaluation enable; 0 freezes state/count/out
//            out        - debounced level (registered)
//            rise       - one-cycle pulse on out 0->1
//            fall       - one-cycle pulse on out 1->0
//            busy       - high while a level change is being qualified
//            glitch_cnt - saturating abort counter (only with
//                         SYNC_DEBOUNCE_GLITCH_CNT_EN defined)
// Macro    : SYNC_DEBOUNCE_GLITCH_CNT_EN - adds glitch_cnt output/register
// Params   : DEBOUNCE_CYCLES (2..255), CNT_W with 2**CNT_W > DEBOUNCE_CYCLES
// Revision : 1.0 - initial release
// ============================================================================
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_async,
    input  logic en,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    // Count value on which the final stable sample is accepted.
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             out_q,   out_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    sync2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in_async),
        .q   (s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE_LO;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Pulses default low every cycle, so they are one cycle wide and are
    // automatically forced low while en=0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE_LO: begin
                    if (s) begin
                        state_d = ST_CHK_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_CHK_HI: begin
                    if (!s) begin
                        state_d = ST_IDLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == C_LAST) begin
                        state_d = ST_IDLE_HI;
                        out_d   = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                ST_IDLE_HI: begin
                    if (!s) begin
                        state_d = ST_CHK_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_CHK_LO: begin
                    if (s) begin
                        state_d = ST_IDLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == C_LAST) begin
                        state_d = ST_IDLE_LO;
                        out_d   = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_CHK_HI) || (state_q == ST_CHK_LO);

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic                abort;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    // An abort is a qualification window broken by the old level returning.
    always_comb begin
        abort    = en && (((state_q == ST_CHK_HI) && !s) ||
                          ((state_q == ST_CHK_LO) &&  s));
        glitch_d = glitch_q;
        if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule : sync_debounce
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_debounce
// Purpose  : Self-checking bench for sync_debounce. A behavioural model
//            tracks the synchronised samples and the length of the current
//            run of samples that disagree with the accepted level; the level
//            flips when that run reaches DEBOUNCE_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_debounce;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_async = 1'b0;
    logic en = 1'b0;
    logic out, rise, fall, busy;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    sync_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_async   (in_async),
        .en         (en),
        .out        (out),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_s1, m_s, m_out, m_rise, m_fall;
    int m_run;
    int m_glitch;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_s1 = 0; m_s = 0; m_out = 0; m_rise = 0; m_fall = 0;
        m_run = 0; m_glitch = 0;
    endfunction

    function automatic void model_step(input bit in_v, input bit en_v);
        m_rise = 0;
        m_fall = 0;
        if (en_v) begin
            if (m_s != m_out) begin
                m_run++;
                if (m_run == DC) begin
                    m_out = m_s;
                    if (m_s) m_rise = 1; else m_fall = 1;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0 && m_glitch < 255) m_glitch++;
                m_run = 0;
            end
        end
        m_s  = m_s1;
        m_s1 = in_v;
    endfunction

    task automatic compare_all();
        check("out",  out,  m_out);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("busy", busy, (m_run > 0));
        check("excl", rise & fall, 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt", glitch_cnt, m_glitch);
`endif
    endtask

    // Drive inputs at negedge, step model at the posedge, compare 1ns later.
    task automatic tick(input bit in_v, input bit en_v);
        @(negedge clk);
        in_async = in_v;
        en       = en_v;
        @(posedge clk);
        #1;
        model_step(in_v, en_v);
        compare_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("rst_out",  out,  0);
        check("rst_busy", busy, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        int hold;
        bit cur_in;
        bit en_v;
        bit seen;
        int g_before;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out",  out,  0);
        check("reset_rise", rise, 0);
        check("reset_fall", fall, 0);
        check("reset_busy", busy, 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        check("reset_glitch", glitch_cnt, 0);
`endif
        #3 rst = 1'b0;

        repeat (3) tick(0, 1);

        // Clean rise: capture at edge 0, accept at edge DC+1
        for (int e = 0; e <= 6; e++) begin
            tick(1, 1);
            if (e == 3) check("rise_busy_e3", busy, 1);
            if (e == 4) check("rise_out_e4", out, 0);
            if (e < 5)  check("rise_early", rise, 0);
            if (e == 5) begin
                check("rise_out_e5", out, 1);
                check("rise_pulse_e5", rise, 1);
            end
            if (e == 6) begin
                check("rise_pulse_e6", rise, 0);
                check("rise_busy_e6", busy, 0);
            end
        end

        // Fall
        for (int e = 0; e <= 6; e++) begin
            tick(0, 1);
            check("fall_norise", rise, 0);
            if (e == 4) check("fall_out_e4", out, 1);
            if (e == 5) begin
                check("fall_out_e5", out, 0);
                check("fall_pulse_e5", fall, 1);
            end
            if (e == 6) check("fall_pulse_e6", fall, 0);
        end

        // Two-sample glitch
        g_before = m_glitch;
        seen = 0;
        tick(1, 1); seen |= rise;
        tick(1, 1); seen |= rise;
        repeat (6) begin tick(0, 1); seen |= rise; end
        check("glitch_out", out, 0);
        check("glitch_norise", seen, 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt1", glitch_cnt, g_before + 1);
`endif

        // Async reset mid-qualification, then rise at edge 5 after release
        repeat (4) tick(1, 1);
        check("pre_rst_busy", busy, 1);
        do_reset();
        for (int e = 0; e <= 5; e++) begin
            tick(1, 1);
            if (e < 5) check("rst_rise_early", rise, 0);
            if (e == 5) check("rst_rise_e5", rise, 1);
        end

        // Return to low before the freeze test
        repeat (8) tick(0, 1);
        check("pre_freeze_out", out, 0);

        // Enable freeze at cnt=2
        repeat (4) tick(1, 1);
        seen = 0;
        repeat (10) begin
            tick(1, 0);
            seen |= rise | fall;
            check("freeze_out", out, 0);
            check("freeze_busy", busy, 1);
        end
        check("freeze_nopulse", seen, 0);
        tick(1, 1);
        check("resume_out1", out, 0);
        tick(1, 1);
        check("resume_out2", out, 1);
        check("resume_rise", rise, 1);

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        // Saturation: 300 single-sample glitches
        repeat (300) begin
            tick(0, 1);
            tick(1, 1);
        end
        repeat (4) tick(1, 1);
        check("glitch_sat", glitch_cnt, 255);
`endif

        // Randomised phase
        hold = 0;
        cur_in = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                cur_in = 1'($urandom_range(0, 1));
                hold   = $urandom_range(1, 8);
            end
            hold--;
            en_v = ($urandom_range(0, 9) != 0);
            tick(cur_in, en_v);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sync_debounce
`default_nettype wire
